// File: rtl/pq_branch_resolver_pkg.sv
// Shared definitions for the branch resolver and the Gshare predictor it updates.
package pq_branch_resolver_pkg;

  localparam int GHRW_DEF    = 8;
  localparam int BHT_IDW_DEF = 6;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_funct3_e;

  typedef enum logic {
    ST_IDLE,
    ST_SQUASH
  } bres_state_e;

  // 010/011 are the only encodings with no branch meaning.
  function automatic logic f3_legal(input logic [2:0] f);
    return f[2] | ~f[1];
  endfunction

endpackage

// File: rtl/pq_branch_cmp.sv
// Combinational RV32I branch condition evaluator.
module pq_branch_cmp
  import pq_branch_resolver_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            legal
);

  always_comb begin
    taken = 1'b0;
    legal = f3_legal(funct3);
    case (funct3)
      F3_BEQ:  taken = (rs1 == rs2);
      F3_BNE:  taken = (rs1 != rs2);
      F3_BLT:  taken = ($signed(rs1) <  $signed(rs2));
      F3_BGE:  taken = ($signed(rs1) >= $signed(rs2));
      F3_BLTU: taken = (rs1 <  rs2);
      F3_BGEU: taken = (rs1 >= rs2);
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/pq_branch_resolver.sv
// Execute-stage branch resolver: predictor update, mispredict redirect, squash window.
// Optional performance counters are built when BRES_PERF_CNT_EN is defined.
//
// state  | meaning
// IDLE   | resolving incoming conditional branches
// SQUASH | redirect issued; wrong-path resolutions are dropped
module pq_branch_resolver
  import pq_branch_resolver_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int GHRW       = GHRW_DEF,
  parameter int BHT_IDW    = BHT_IDW_DEF,
  parameter int SQUASH_CYC = 2,
  localparam int BPCW      = BHT_IDW + 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_br_valid,
  input  logic            i_is_op_branch,
  input  logic            i_is_op_jal,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_pc,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic [XLEN-1:0] i_immB,
  input  logic            i_pred_btaken,
  input  logic [GHRW-1:0] i_ghr_snapshot,
  output logic            o_upd_ghr,
  output logic            o_upd_bht,
  output logic [BPCW-1:0] o_upd_idx_pc,
  output logic [GHRW-1:0] o_upd_idx_ghr,
  output logic            o_actual_btaken,
  output logic            o_redirect,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_squash,
  output logic [31:0]     o_perf_nbranch,
  output logic [31:0]     o_perf_nmispred
);

  bres_state_e state;
  logic [3:0]  sq_cnt;

  logic            taken;
  logic            legal;
  logic            cond_br;
  logic            accept;
  logic            mispred;
  logic [XLEN-1:0] target;

  pq_branch_cmp #(.XLEN(XLEN)) u_cmp (
    .funct3 (i_funct3),
    .rs1    (i_rs1),
    .rs2    (i_rs2),
    .taken  (taken),
    .legal  (legal)
  );

  // JAL is always predicted taken at fetch, so it never reaches resolution here.
  assign cond_br = i_is_op_branch & ~i_is_op_jal;
  assign accept  = i_br_valid & cond_br & ~i_stall & (state == ST_IDLE);
  assign mispred = accept & (taken != i_pred_btaken);
  assign target  = taken ? (i_pc + i_immB) : (i_pc + XLEN'(4));

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      sq_cnt          <= '0;
      o_upd_ghr       <= 1'b0;
      o_upd_bht       <= 1'b0;
      o_upd_idx_pc    <= '0;
      o_upd_idx_ghr   <= '0;
      o_actual_btaken <= 1'b0;
      o_redirect      <= 1'b0;
      o_redirect_pc   <= '0;
      o_squash        <= 1'b0;
    end else begin
      o_upd_ghr  <= accept & legal;
      o_upd_bht  <= accept & legal;
      o_redirect <= mispred;
      if (accept) begin
        o_actual_btaken <= taken;
      end
      if (accept & legal) begin
        o_upd_idx_pc  <= i_pc[BPCW-1:0];
        o_upd_idx_ghr <= i_ghr_snapshot;
      end
      if (mispred) begin
        o_redirect_pc <= target;
      end
      case (state)
        ST_IDLE: begin
          if (mispred) begin
            state    <= ST_SQUASH;
            sq_cnt   <= 4'(SQUASH_CYC);
            o_squash <= 1'b1;
          end
        end
        ST_SQUASH: begin
          // Counter runs regardless of stall: the window is in wall-clock cycles.
          if (sq_cnt <= 4'd1) begin
            state    <= ST_IDLE;
            sq_cnt   <= '0;
            o_squash <= 1'b0;
          end else begin
            sq_cnt <= sq_cnt - 4'd1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          sq_cnt   <= '0;
          o_squash <= 1'b0;
        end
      endcase
    end
  end

`ifdef BRES_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      o_perf_nbranch  <= '0;
      o_perf_nmispred <= '0;
    end else begin
      if (accept && legal && (o_perf_nbranch != 32'hFFFF_FFFF)) begin
        o_perf_nbranch <= o_perf_nbranch + 32'd1;
      end
      if (mispred && (o_perf_nmispred != 32'hFFFF_FFFF)) begin
        o_perf_nmispred <= o_perf_nmispred + 32'd1;
      end
    end
  end
`else
  assign o_perf_nbranch  = '0;
  assign o_perf_nmispred = '0;
`endif

endmodule
